// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the shared ALU and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    // Requester side
    logic             req0;
    logic             req1;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;

    // Shared ALU side
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_f;
    logic             alu_of;
    logic             alu_zf;

    // Responses and status
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] f;
    logic             of;
    logic             zf;
    logic             busy;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_f, alu_of, alu_zf,
        output alu_op, alu_a, alu_b, gnt0, gnt1, done0, done1, f, of, zf, busy, cnt0, cnt1
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_f, alu_of, alu_zf,
        input  alu_op, alu_a, alu_b, gnt0, gnt1, done0, done1, f, of, zf, busy, cnt0, cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each request runs IDLE -> EXEC -> RESP: operands latched at grant, result
// captured at the end of EXEC, one-cycle DONE pulse in RESP.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_q;       // most recently granted requester
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] f_q;
    logic             of_q;
    logic             zf_q;
    logic [7:0]       cnt0_q;
    logic [7:0]       cnt1_q;
    logic             take;         // latch operands this edge
    logic             sel;          // requester chosen in IDLE

    // Next-state, grant selection and decoded outputs
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        sel       = 1'b0;
        bus.gnt0  = 1'b0;
        bus.gnt1  = 1'b0;
        bus.done0 = 1'b0;
        bus.done1 = 1'b0;
        bus.busy  = 1'b1;
        unique case (state_q)
            StIdle: begin
                bus.busy = 1'b0;
                if (bus.req0 || bus.req1) begin
                    take    = 1'b1;
                    state_d = StExec;
                    // Contention goes to whoever was not served last
                    sel     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                end
            end
            StExec: begin
                state_d  = StResp;
                bus.gnt0 = ~last_q;
                bus.gnt1 = last_q;
            end
            StResp: begin
                state_d   = StIdle;
                bus.gnt0  = ~last_q;
                bus.gnt1  = last_q;
                bus.done0 = ~last_q;
                bus.done1 = last_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, operand latch, result capture and completion counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_q <= sel;
                op_q   <= sel ? bus.op1 : bus.op0;
                a_q    <= sel ? bus.a1  : bus.a0;
                b_q    <= sel ? bus.b1  : bus.b0;
            end
            // Counter steps with the capture so it is already valid alongside DONE
            if (state_q == StExec) begin
                f_q  <= bus.alu_f;
                of_q <= bus.alu_of;
                zf_q <= bus.alu_zf;
                if (last_q) cnt1_q <= cnt1_q + 8'd1;
                else        cnt0_q <= cnt0_q + 8'd1;
            end
        end
    end

    // Latched operands only change at grant, so they double as the held ALU drive
    assign bus.alu_op = op_q;
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;
    assign bus.f      = f_q;
    assign bus.of     = of_q;
    assign bus.zf     = zf_q;
    assign bus.cnt0   = cnt0_q;
    assign bus.cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses,
// a monitor pops and compares on every DONE pulse.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam logic [2:0] OpAdd = 3'b100;
    localparam logic [2:0] OpSub = 3'b101;

    typedef struct {
        int          idx;
        logic [31:0] f;
        logic        of;
        logic        zf;
        logic [7:0]  cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] cnt_model [2];

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 100 add, 101 sub, 000 and, 001 or; signed overflow
    always_comb begin
        logic [31:0] r;
        r = '0;
        bus.alu_of = 1'b0;
        case (bus.alu_op)
            3'b100: begin
                r = bus.alu_a + bus.alu_b;
                bus.alu_of = (bus.alu_a[31] == bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            3'b101: begin
                r = bus.alu_a - bus.alu_b;
                bus.alu_of = (bus.alu_a[31] != bus.alu_b[31]) && (r[31] != bus.alu_a[31]);
            end
            3'b000:  r = bus.alu_a & bus.alu_b;
            3'b001:  r = bus.alu_a | bus.alu_b;
            default: r = '0;
        endcase
        bus.alu_f  = r;
        bus.alu_zf = (r == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest expected response
    always @(negedge clk) begin
        if (bus.done0 || bus.done1) begin
            check("done_onehot", {31'd0, bus.done0 & bus.done1}, 32'd0);
            check("gnt_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_idx", {31'd0, bus.done1}, mon_e.idx);
                check("f", bus.f, mon_e.f);
                check("of", {31'd0, bus.of}, {31'd0, mon_e.of});
                check("zf", {31'd0, bus.zf}, {31'd0, mon_e.zf});
                check("cnt", {24'd0, mon_e.idx == 1 ? bus.cnt1 : bus.cnt0}, {24'd0, mon_e.cnt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cnt_model[0] = '0;
        cnt_model[1] = '0;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] ef, input logic eof,
                            input logic ezf);
        exp_t e;
        cnt_model[idx] = cnt_model[idx] + 8'd1;
        e.idx = idx;
        e.f   = ef;
        e.of  = eof;
        e.zf  = ezf;
        e.cnt = cnt_model[idx];
        sb.push_back(e);
    endtask

    // One isolated request; optionally rewrite the A operand during EXEC
    task automatic do_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ef, input logic eof,
                          input logic ezf, input bit poke, input logic [31:0] poke_a);
        push_exp(idx, ef, eof, ezf);
        if (idx == 0) begin
            bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
        end
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (poke) begin
            if (idx == 0) bus.a0 = poke_a;
            else          bus.a1 = poke_a;
        end
        @(negedge clk);
        check("gnt_exec", {31'd0, idx == 1 ? bus.gnt1 : bus.gnt0}, 32'd1);
        check("busy_exec", {31'd0, bus.busy}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = '0; bus.op1 = '0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        // Reset state
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        check("rst_f", bus.f, 32'd0);
        check("rst_flags", {30'd0, bus.of, bus.zf}, 32'd0);
        check("rst_cnt", {16'd0, bus.cnt1, bus.cnt0}, 32'd0);
        check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
        check("rst_alu_ab", bus.alu_a | bus.alu_b, 32'd0);
        tick();
        rst_n = 1'b1;
        cnt_model[0] = '0;
        cnt_model[1] = '0;

        // Single ADD from requester 0
        do_req(0, OpAdd, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0);
        check("alu_hold_op", {29'd0, bus.alu_op}, {29'd0, OpAdd});
        check("alu_hold_a", bus.alu_a, 32'd5);

        // Contention after reset: 0,1,0,1 with both held
        do_reset();
        bus.op0 = OpAdd; bus.a0 = 32'd10; bus.b0 = 32'd20;
        bus.op1 = OpSub; bus.a1 = 32'd50; bus.b1 = 32'd8;
        push_exp(0, 32'd30, 1'b0, 1'b0);
        push_exp(1, 32'd42, 1'b0, 1'b0);
        push_exp(0, 32'd30, 1'b0, 1'b0);
        push_exp(1, 32'd42, 1'b0, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            if (g == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            @(negedge clk);
            check("rr_gnt", {30'd0, bus.gnt1, bus.gnt0}, (g % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
        end

        // SUB to zero, then signed overflow; result holds in IDLE
        do_req(1, OpSub, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_req(1, OpSub, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0,
               1'b0, 32'd0);
        tick();
        @(negedge clk);
        check("f_hold", bus.f, 32'h8000_0000);

        // Operand change during EXEC is ignored
        do_req(0, OpAdd, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0, 1'b1, 32'd999);

        // Reset during EXEC aborts the operation
        do_reset();
        bus.req0 = 1'b1; bus.op0 = OpAdd; bus.a0 = 32'd1; bus.b0 = 32'd1;
        tick();
        bus.req0 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done0}, 32'd0);
        check("abort_cnt0", {24'd0, bus.cnt0}, 32'd0);
        tick();
        tick();

        // 256 completions from requester 0 wrap CNT0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            do_req(0, OpAdd, i, 32'd1, i + 1, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        tick();
        @(negedge clk);
        check("wrap_cnt0", {24'd0, bus.cnt0}, 32'd0);
        check("wrap_cnt1", {24'd0, bus.cnt1}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 REQ0 / REQ1  input  1 each  request from requester 0 / 1 (level).
REQ-005 OP0 / OP1  input  3 each  ALU_OP code from requester 0 / 1.
REQ-006 A0 / B0 / A1 / B1  input  WIDTH each  operands from requester 0 / 1.
REQ-007 ALU_OP  output  3  op code driven to the shared ALU.
REQ-008 ALU_A / ALU_B  output  WIDTH each  operands driven to the shared ALU.
REQ-009 ALU_F  input  WIDTH  combinational ALU result.
REQ-010 ALU_OF / ALU_ZF  input  1 each  combinational ALU overflow / zero flags.
REQ-011 GNT0 / GNT1  output  1 each  high while the request is being served (EXEC and RESP).
REQ-012 DONE0 / DONE1  output  1 each  one-cycle pulse marking a valid response.
REQ-013 F  output  WIDTH  registered result; OF / ZF  output  1 each  registered flags.
REQ-014 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-015 CNT0 / CNT1  output  8 each  completed-operation counters per requester.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-017 IDLE: if any REQx is high at the clock edge, latch that requester's OPx/Ax/Bx into internal registers, record the granted index, and go to EXEC; otherwise stay in IDLE.
REQ-018 If REQ0 and REQ1 are both high in IDLE, grant the requester not equal to the LAST register (round-robin); LAST updates to the granted index at grant.
REQ-019 If only one request is present, grant it regardless of LAST; LAST still updates.
REQ-020 EXEC lasts one cycle: ALU_OP/ALU_A/ALU_B are driven from the latched registers; at its closing edge, ALU_F/ALU_OF/ALU_ZF are captured into F/OF/ZF and the FSM goes to RESP.
REQ-021 Outside EXEC, ALU_OP, ALU_A and ALU_B SHALL hold their last driven values; they do not follow requester inputs.
REQ-022 RESP lasts one cycle: DONEx of the granted requester is high, F/OF/ZF are valid, the granted CNTx increments, and the FSM unconditionally returns to IDLE.
REQ-023 Latency: REQx sampled at edge k gives EXEC in cycle k+1 and DONEx in cycle k+2; the minimum issue interval is 3 cycles.
REQ-024 Operands are latched at grant, so requesters may change OPx/Ax/Bx from the cycle after GNTx first rises.
REQ-025 A requester SHALL drop REQx in the cycle after DONEx; REQx still high in the IDLE cycle after RESP counts as a new request.
REQ-026 F/OF/ZF SHALL hold their values until the next EXEC capture.
REQ-027 CNTx is 8-bit modulo; 255 + 1 wraps to 0 without any flag.
REQ-028 A REQx change during EXEC/RESP has no effect on the operation in flight; it is evaluated in the next IDLE.
REQ-029 At most one GNTx and at most one DONEx SHALL be high in any cycle.

Reset
REQ-030 When rst_n is low at an edge, the block SHALL set: state IDLE, LAST=1, GNT0/GNT1/DONE0/DONE1/BUSY=0, F=0, OF=0, ZF=0, CNT0=CNT1=0, ALU_OP=0, ALU_A=0, ALU_B=0, latched operand registers 0.
REQ-031 Reset asserted during EXEC or RESP aborts the operation: no DONE pulse is produced and no counter increments.
REQ-032 Reset dominates every other event in the same cycle.

Verification
REQ-033 After reset, REQ0 alone with OP0=100 (ADD), A0=5, B0=3 -> GNT0 at k+1, DONE0 at k+2 with F=8, OF=0, ZF=0, CNT0=1.
REQ-034 After reset, REQ0 and REQ1 both high -> requester 0 served first; with REQ1 held, requester 1 is served next; with both held continuously, grants alternate 0,1,0,1.
REQ-035 REQ1 with OP1=101 (SUB), A1=7, B1=7 -> DONE1 with F=0, ZF=1; then A1=32'h7FFFFFFF, B1=32'hFFFFFFFF -> OF=1.
REQ-036 Change A0 to a new value during EXEC -> F reflects the operand latched at grant.
REQ-037 rst_n low in the EXEC cycle -> next cycle IDLE, no DONE pulse, CNT unchanged at 0, BUSY=0.
REQ-038 256 completed requests from requester 0 -> CNT0 wraps to 0; CNT1 remains 0.
